mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller on the riscvmulti data bus, beside the RAM.
- Decodes addresses with addr[8]=1 and holds the LED and HEX output registers.
- Synchronises and debounces the KEY/SW board inputs, captures key-press events, and drives the 7-segment displays.
- Muxes I/O read data with RAM read data to form the CPU's readdata.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples before a KEY/SW change is accepted (board builds use 50000).
- N_KEYS, 4, number of push buttons.
- N_SW, 10, number of slide switches.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
- addr  in  32  CPU byte address.
- writedata  in  32  CPU store data.
- memwrite  in  1  CPU store strobe.
- ram_rdata  in  32  read data from RAM.
- readdata  out  32  read data returned to the CPU.
- ledr  out  10  LED register.
- hex_n  out  42  six 7-segment digits, active-low; digit i occupies [7i+6:7i], segment order g..a.
- key_n  in  N_KEYS  raw push buttons, active-low, asynchronous.
- sw  in  N_SW  raw slide switches, asynchronous.

Behaviour:
- Decode: is_io = addr[8]. Field selects are addr[2] LEDS (0x104), addr[3] HEX (0x108), addr[4] KEY (0x110), addr[5] SW (0x120). Selects are independent; several may be active at once.
- Writes: on the rising edge of clk when memwrite & is_io:
  - if the LEDS select is active, ledr <= writedata[9:0];
  - if the HEX select is active, hex_digits <= writedata[23:0];
  - if the KEY select is active, key_edge <= key_edge & ~writedata[N_KEYS-1:0] (write-1-to-clear).
  - All selected fields update in the same cycle. Writes with is_io=0 have no effect.
- Reads: combinational, zero latency.
  - If is_io=0, readdata = ram_rdata.
  - If is_io=1, readdata = bitwise OR of the selected fields, zero-extended:
    - LEDS: {22'b0, ledr}
    - HEX: {8'b0, hex_digits}
    - KEY: {24'b0, key_edge[3:0], key_pressed[3:0]}
    - SW: {22'b0, sw_db}
  - is_io=1 with no select active returns 0.
  - A value written at edge k is readable in the cycle after edge k.
- Input path, per bit:
  - Two-flop synchroniser, then debouncer.
  - Debouncer holds a stable value and a counter. While the synchronised value equals the stable value, the counter is 0. While it differs, the counter increments each cycle. When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, stable <= synchronised value and the counter returns to 0.
  - A clean input step appears on the stable output 2+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at the synchroniser output is rejected, and the counter restarts from 0.
- Keys:
  - key_pressed = ~key_db.
  - key_edge[i] sets on the cycle key_pressed[i] rises 0->1, then holds until cleared by software.
  - If a set and a clear of the same bit happen in the same cycle, the set wins.
- HEX:
  - Each 4-bit nibble of hex_digits is decoded to active-low segments: 0-9 and A-F, with lowercase b and d.
  - Nibble i drives digit i. The decode is combinational from the register.
- Reset (reset==0 at a rising edge):
  - ledr=0, hex_digits=0, so hex_n shows "000000" (each digit 7'b1000000).
  - key_edge=0.
  - Key synchronisers and stable values = 1 (released); switch synchronisers and stable values = 0; all counters = 0.
  - Reset overrides any simultaneous write.
  - Asserting reset mid-debounce discards the pending change. After release, the change is re-qualified from scratch.

Decomposition:
- Package mmio_pkg holds:
  - IO_BASE_BIT=8, IO_LEDS_BIT=2, IO_HEX_BIT=3, IO_KEY_BIT=4, IO_SW_BIT=5;
  - the 16-entry 7-segment constant table;
  - DEBOUNCE width helper (clog2).
- Sub-module io_debounce (synchroniser + debouncer, parameters DEBOUNCE_CYCLES and RESET_VAL), instantiated N_KEYS+N_SW times.
- The HEX decoder is a package function, not a module.

Test Plan:
- Reset then idle -> ledr=0, hex_n digits all 7'b1000000, readdata at 0x110 = 0, readdata at 0x120 = 0.
- Store 0x3FF to 0x104, then 0x00ABCDEF to 0x108 -> ledr=0x3FF next cycle; hex_n digit0=F (7'b0001110), digit5=0; loads return 0x3FF and 0x00ABCDEF; store to 0x10C writes both registers.
- With DEBOUNCE_CYCLES=4, sw[3] steps 0->1 -> readdata at 0x120 = 0x008 exactly 6 cycles later; a 2-cycle pulse on sw[4] never appears.
- Drive key_n[1]=0 for 10 cycles, then release -> 0x110 reads 0x22 while held, 0x20 after release; store 0x2 to 0x110 -> reads 0x00.
- Press key 0 in the same cycle as a store of 0x1 to 0x110 -> key_edge[0] remains 1.
- Store with addr[8]=0 -> ledr unchanged, readdata = ram_rdata; reset asserted mid-debounce of sw[0] -> sw_db stays 0 until 6 cycles after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and helpers for the memory-mapped I/O controller.
//   - address bit positions for the I/O window and its field selects
//   - 7-segment decode table (active-low, segment order g..a)
//   - counter width helper for the input debouncers
package mmio_pkg;

  localparam int IO_BASE_BIT = 8;
  localparam int IO_LEDS_BIT = 2;
  localparam int IO_HEX_BIT  = 3;
  localparam int IO_KEY_BIT  = 4;
  localparam int IO_SW_BIT   = 5;

  // Active-low segments {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser followed by a counter debouncer for one
// asynchronous board input.
//   clk      system clock
//   reset    synchronous active-low reset
//   i_raw    raw asynchronous input
//   o_stable debounced level; changes only after DEBOUNCE_CYCLES consecutive
//            synchronised samples that differ from the current stable level
module io_debounce
  import mmio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam int               CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= RESET_VAL;
      r_sync2  <= RESET_VAL;
      r_stable <= RESET_VAL;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample that agrees with the stable level restarts qualification.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block beside the RAM on the CPU data bus.
//   clk, reset          clock and synchronous active-low reset
//   addr, writedata     CPU byte address and store data
//   memwrite            CPU store strobe
//   ram_rdata           RAM read data, passed through when addr[8]=0
//   readdata            data returned to the CPU (combinational)
//   ledr                LED register
//   hex_n               six active-low 7-segment digits, digit i at [7i+6:7i]
//   key_n               raw active-low push buttons
//   sw                  raw slide switches
// I/O map (addr[8]=1): addr[2] LEDS, addr[3] HEX, addr[4] KEY, addr[5] SW.
// Selects are independent, so one access may touch several fields.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  input  logic              memwrite,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       readdata,
  output logic [9:0]        ledr,
  output logic [41:0]       hex_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw
);

  logic              w_is_io;
  logic              w_sel_leds;
  logic              w_sel_hex;
  logic              w_sel_key;
  logic              w_sel_sw;
  logic              w_wr;
  logic [N_KEYS-1:0] w_key_db;
  logic [N_KEYS-1:0] w_key_pressed;
  logic [N_KEYS-1:0] w_key_clr;
  logic [N_SW-1:0]   w_sw_db;
  logic              w_unused;

  logic [9:0]        r_ledr;
  logic [23:0]       r_hex;
  logic [N_KEYS-1:0] r_key_edge;
  logic [N_KEYS-1:0] r_key_prev;

  assign w_is_io    = addr[IO_BASE_BIT];
  assign w_sel_leds = addr[IO_LEDS_BIT];
  assign w_sel_hex  = addr[IO_HEX_BIT];
  assign w_sel_key  = addr[IO_KEY_BIT];
  assign w_sel_sw   = addr[IO_SW_BIT];
  assign w_wr       = memwrite & w_is_io;

  assign w_unused = ^{addr[31:9], addr[7:6], addr[1:0], writedata[31:24]};

  for (genvar gk = 0; gk < N_KEYS; gk++) begin : g_key
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (key_n[gk]),
      .o_stable(w_key_db[gk])
    );
  end

  for (genvar gs = 0; gs < N_SW; gs++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (sw[gs]),
      .o_stable(w_sw_db[gs])
    );
  end

  assign w_key_pressed = ~w_key_db;
  assign w_key_clr     = (w_wr && w_sel_key) ? writedata[N_KEYS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ledr     <= '0;
      r_hex      <= '0;
      r_key_edge <= '0;
      r_key_prev <= '0;
    end else begin
      if (w_wr && w_sel_leds) r_ledr <= writedata[9:0];
      if (w_wr && w_sel_hex)  r_hex  <= writedata[23:0];
      r_key_prev <= w_key_pressed;
      // The new-press term is OR'd in after the clear so a press wins.
      r_key_edge <= (r_key_edge & ~w_key_clr) | (w_key_pressed & ~r_key_prev);
    end
  end

  always_comb begin
    readdata = ram_rdata;
    if (w_is_io) begin
      readdata = '0;
      if (w_sel_leds) readdata = readdata | {22'b0, r_ledr};
      if (w_sel_hex)  readdata = readdata | {8'b0, r_hex};
      if (w_sel_key)  readdata = readdata | 32'({r_key_edge, w_key_pressed});
      if (w_sel_sw)   readdata = readdata | 32'(w_sw_db);
    end
  end

  assign ledr = r_ledr;

  for (genvar gh = 0; gh < 6; gh++) begin : g_hex
    assign hex_n[7*gh +: 7] = hex7(r_hex[4*gh +: 4]);
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] ram_rdata;
  logic [31:0] readdata;
  logic [9:0]  ledr;
  logic [41:0] hex_n;
  logic [3:0]  key_n;
  logic [9:0]  sw;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .N_KEYS         (4),
    .N_SW           (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .writedata(writedata),
    .memwrite (memwrite),
    .ram_rdata(ram_rdata),
    .readdata (readdata),
    .ledr     (ledr),
    .hex_n    (hex_n),
    .key_n    (key_n),
    .sw       (sw)
  );

  always #5 clk = ~clk;

  // One store cycle: drive at negedge, commit on the posedge, drop at negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; addr = '0; writedata = '0; memwrite = 1'b0;
    ram_rdata = '0; key_n = 4'hF; sw = '0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    n_checks++;
    if (ledr !== 10'h000) begin
      n_fail++; $display("FAIL reset_ledr got=%h exp=%h", ledr, 10'h000);
    end
    n_checks++;
    if (hex_n !== {6{7'b1000000}}) begin
      n_fail++; $display("FAIL reset_hex got=%h exp=%h", hex_n, {6{7'b1000000}});
    end
    addr = 32'h110; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_key_rd got=%h exp=%h", readdata, 32'h0);
    end
    addr = 32'h120; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_sw_rd got=%h exp=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_leds_hex;
    store(32'h104, 32'h3FF);
    n_checks++;
    if (ledr !== 10'h3FF) begin
      n_fail++; $display("FAIL led_write got=%h exp=%h", ledr, 10'h3FF);
    end
    store(32'h108, 32'h00ABCDEF);
    n_checks++;
    if (hex_n[6:0] !== 7'b0001110) begin
      n_fail++; $display("FAIL hex_digit0 got=%b exp=%b", hex_n[6:0], 7'b0001110);
    end
    // digits 5..0 = A b C d E F
    n_checks++;
    if (hex_n !== {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}) begin
      n_fail++; $display("FAIL hex_all got=%h exp=%h", hex_n,
        {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110});
    end
    addr = 32'h104; #1;
    n_checks++;
    if (readdata !== 32'h000003FF) begin
      n_fail++; $display("FAIL led_read got=%h exp=%h", readdata, 32'h3FF);
    end
    addr = 32'h108; #1;
    n_checks++;
    if (readdata !== 32'h00ABCDEF) begin
      n_fail++; $display("FAIL hex_read got=%h exp=%h", readdata, 32'h00ABCDEF);
    end
    addr = 32'h10C; #1;
    n_checks++;
    if (readdata !== 32'h00ABCFFF) begin
      n_fail++; $display("FAIL or_read got=%h exp=%h", readdata, 32'h00ABCFFF);
    end
    store(32'h10C, 32'h00123155);
    n_checks++;
    if (ledr !== 10'h155) begin
      n_fail++; $display("FAIL dual_led got=%h exp=%h", ledr, 10'h155);
    end
    // digits 5..0 = 1 2 3 1 5 5
    n_checks++;
    if (hex_n !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b1111001, 7'b0010010, 7'b0010010}) begin
      n_fail++; $display("FAIL dual_hex got=%h exp=%h", hex_n,
        {7'b1111001, 7'b0100100, 7'b0110000, 7'b1111001, 7'b0010010, 7'b0010010});
    end
    addr = 32'h100; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL io_nosel got=%h exp=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_sw_debounce;
    addr = 32'h120;
    sw[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      n_checks++;
      if (readdata !== ((k < 6) ? 32'h0 : 32'h8)) begin
        n_fail++; $display("FAIL sw_step k=%0d got=%h exp=%h", k, readdata,
                           (k < 6) ? 32'h0 : 32'h8);
      end
    end
  endtask

  task automatic test_glitch;
    addr = 32'h120;
    sw[4] = 1'b1;
    cycles(2);
    sw[4] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      n_checks++;
      if (readdata !== 32'h8) begin
        n_fail++; $display("FAIL sw_glitch k=%0d got=%h exp=%h", k, readdata, 32'h8);
      end
    end
  endtask

  task automatic test_key;
    addr = 32'h110;
    key_n[1] = 1'b0;
    cycles(10);
    n_checks++;
    if (readdata !== 32'h22) begin
      n_fail++; $display("FAIL key_held got=%h exp=%h", readdata, 32'h22);
    end
    key_n[1] = 1'b1;
    cycles(8);
    n_checks++;
    if (readdata !== 32'h20) begin
      n_fail++; $display("FAIL key_released got=%h exp=%h", readdata, 32'h20);
    end
    store(32'h110, 32'h2);
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL key_clear got=%h exp=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_key_set_clear;
    addr = 32'h110;
    key_n[0] = 1'b0;
    cycles(6);
    #1;
    n_checks++;
    if (readdata !== 32'h01) begin
      n_fail++; $display("FAIL key0_pressed got=%h exp=%h", readdata, 32'h01);
    end
    // Edge bit sets on the next posedge, exactly when this clear lands.
    store(32'h110, 32'h1);
    #1;
    n_checks++;
    if (readdata !== 32'h11) begin
      n_fail++; $display("FAIL set_beats_clear got=%h exp=%h", readdata, 32'h11);
    end
    key_n[0] = 1'b1;
    cycles(8);
    store(32'h110, 32'h1);
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL key0_clear got=%h exp=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_ram_passthrough;
    ram_rdata = 32'hDEADBEEF;
    store(32'h004, 32'h3);
    store(32'h204, 32'h2);
    n_checks++;
    if (ledr !== 10'h155) begin
      n_fail++; $display("FAIL ram_store_led got=%h exp=%h", ledr, 10'h155);
    end
    addr = 32'h004; #1;
    n_checks++;
    if (readdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ram_read got=%h exp=%h", readdata, 32'hDEADBEEF);
    end
    addr = 32'h0A4; #1;
    n_checks++;
    if (readdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ram_read_sel got=%h exp=%h", readdata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_reset_mid_debounce;
    sw[0] = 1'b1;
    cycles(3);
    // Reset while a store to LEDS is also on the bus.
    reset = 1'b0; addr = 32'h104; writedata = 32'h2AA; memwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; memwrite = 1'b0;
    n_checks++;
    if (ledr !== 10'h000) begin
      n_fail++; $display("FAIL reset_over_write got=%h exp=%h", ledr, 10'h000);
    end
    addr = 32'h120;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      n_checks++;
      if (readdata !== ((k < 6) ? 32'h0 : 32'h9)) begin
        n_fail++; $display("FAIL sw_requal k=%0d got=%h exp=%h", k, readdata,
                           (k < 6) ? 32'h0 : 32'h9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_leds_hex();
    test_sw_debounce();
    test_glitch();
    test_key();
    test_key_set_clear();
    test_ram_passthrough();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
